dac7611_serial_rx: RTL
======================

Name: dac7611_serial_rx

Overview:
- Synthesizable receiver for the DAC7611 4-wire serial write interface (CLK, SDI, LD, CLR) driven by our DAC7611 transmitter.
- Decodes frames into the 12-bit code the DAC would latch, flags malformed frames, and counts errors.
- Used for on-board loopback self-test on ZCU102 (TX pins looped to RX pins) and as a synthesizable checker in system benches.

Parameters:
- DATA_W, 12, serial word width; MSB first.
- ERR_CNT_W, 8, width of the saturating frame-error counter.

Ports:
- clk  input  1  fabric clock; at least as fast as the transmitter's state clock.
- reset  input  1  synchronous, active-high reset.
- dac_signals_15  input  4  bus: [3]=CLK, [2]=SDI, [1]=LD, [0]=CLR; asynchronous to clk.
- dac_code  output  DATA_W  last successfully loaded code.
- load_pulse  output  1  one-cycle strobe when dac_code updates from a good frame.
- clr_active  output  1  registered synced CLR-low level.
- frame_err  output  1  one-cycle strobe on LD fall with bit count != DATA_W.
- err_cnt  output  ERR_CNT_W  saturating count of frame_err strobes.

Behaviour:
- Input sync: 2-FF synchronizer per line plus one history flop. Sync/history flops reset to 1 (all lines idle high), so reset release produces no false edge.
- Edges are taken from the history flop vs the second sync flop:
  - clk_rise: CLK 0->1.
  - ld_fall: LD 1->0.
- Input CLK high and low phases must each be >= 2 clk periods. Narrower pulses are undefined.
- State: shift_reg[DATA_W-1:0] and bit_cnt[4:0], where bit_cnt saturates at 31.
- Priority per cycle is CLR > ld_fall > clk_rise:
  - CLR synced low (level): dac_code, shift_reg and bit_cnt go to 0; clr_active=1; clk_rise and ld_fall are ignored; no strobes.
  - ld_fall with bit_cnt==DATA_W: dac_code<=shift_reg; load_pulse=1; bit_cnt<=0.
  - ld_fall with bit_cnt!=DATA_W (including 0): dac_code holds; frame_err=1; err_cnt+1 (saturating at all-ones); bit_cnt<=0.
  - clk_rise with synced LD high: shift_reg<={shift_reg[DATA_W-2:0],SDI}; bit_cnt+1. With synced LD low, clk_rise is ignored.
  - A clk_rise coincident with ld_fall is dropped.
- Overrun: more than DATA_W bits before LD fall gives frame_err. The last DATA_W bits are still held in shift_reg but are not loaded.
- Latency: a strobe appears on the 3rd rising clk edge counting the first edge that samples LD low. dac_code updates in the same cycle as load_pulse.
- Reset values: dac_code=0, load_pulse=0, clr_active=0, frame_err=0, err_cnt=0, shift_reg=0, bit_cnt=0.
- Reset mid-frame: the partial frame is discarded with no strobe.
- The CLR level survives sync latency, so the first cycle after reset reflects pins only after 2 clk.

Optional Feature:
- Macro: DAC7611_RX_GLITCH_FILTER_EN.
- Defined: each synced line passes a 2-sample agreement filter; the filtered value changes only when two consecutive synced samples agree. This adds 1 cycle to all latencies, and a single-cycle glitch never produces an edge. Minimum input phase width becomes 3 clk.
- Undefined: no filter; behaviour exactly as above.

Decomposition:
- Package dac7611_pkg:
  - Bit-index constants CLK_IDX=3, SDI_IDX=2, LD_IDX=1, CLR_IDX=0.
  - DAC_DATA_W=12.
  - Shared with the transmitter.
- Sub-module dac_rx_sync_edge: 1-bit synchronizer, history flop, optional filter, rise/fall outputs. Instantiated once per line (4x).

Test Plan:
- Standard frame 0,1,0,1,... MSB first (12 bits), CLK phases of 2 clk, then LD low for 2 clk -> dac_code=12'h555, single load_pulse 3 edges after LD low sampled, frame_err=0.
- Frame 12'hFFF then frame 12'h000 back-to-back -> two load_pulses, dac_code 12'hFFF then 12'h000, err_cnt=0.
- 11 clocks then LD fall -> frame_err pulse, dac_code holds prior value, err_cnt=1. A 13-clock frame -> err_cnt=2.
- CLR low for 2 clk mid-frame after 6 bits, then a full 12'hA5C frame -> clr_active=1 and dac_code=0 during CLR; the next frame loads 12'hA5C with no frame_err.
- Assert reset after 7 bits, then send a full 12'h3C3 frame -> all outputs 0 during reset, no strobe from the partial frame, 12'h3C3 loaded.
- With DAC7611_RX_GLITCH_FILTER_EN defined: 1-clk glitch on CLK during a frame -> no extra bit, frame 12'h555 loads cleanly, latency 4 edges. Without the macro, the same glitch -> frame_err.

Source files
------------

// File: rtl/dac7611_pkg.sv
// DAC7611 serial interface definitions shared by the transmitter and receiver.
//   CLK_IDX/SDI_IDX/LD_IDX/CLR_IDX : bit positions of the pins on the 4-bit bus
//   DAC_DATA_W                     : DAC word width (MSB first on the wire)
//   rx_event_e / rx_event()        : per-cycle receiver action after priority resolution
package dac7611_pkg;

   localparam int CLK_IDX    = 3;
   localparam int SDI_IDX    = 2;
   localparam int LD_IDX     = 1;
   localparam int CLR_IDX    = 0;
   localparam int DAC_DATA_W = 12;
   localparam int BIT_CNT_W  = 5;

   typedef enum logic [1:0] {
      EV_NONE,
      EV_CLEAR,
      EV_LATCH,
      EV_SHIFT
   } rx_event_e;

   // CLR level beats LD fall, which beats a CLK rise; a CLK rise while LD
   // is low (or on the same cycle LD falls) is discarded.
   function automatic rx_event_e rx_event(input logic clr_n,
                                          input logic ld_fall,
                                          input logic clk_rise,
                                          input logic ld_high);
      if (!clr_n)              return EV_CLEAR;
      if (ld_fall)             return EV_LATCH;
      if (clk_rise && ld_high) return EV_SHIFT;
      return EV_NONE;
   endfunction

endpackage

// File: rtl/dac_rx_sync_edge.sv
// Single-line synchronizer with edge detection for an asynchronous DAC pin.
// Optional macro: DAC7611_RX_GLITCH_FILTER_EN adds a 2-sample agreement filter
// (one extra cycle of latency, single-cycle glitches are swallowed).
//   clk, reset : fabric clock, synchronous active-high reset
//   din        : asynchronous pin
//   level      : synchronized (and optionally filtered) level
//   rise, fall : one-cycle edge indications on level
module dac_rx_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic s1, s2, hist, filt;

   // Everything resets to the idle-high pin level so reset release is edge-free.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
      end else begin
         s1 <= din;
         s2 <= s1;
      end
   end

`ifdef DAC7611_RX_GLITCH_FILTER_EN
   logic s3;

   always_ff @(posedge clk) begin
      if (reset) s3 <= 1'b1;
      else       s3 <= s2;
   end

   // hist holds the last filtered value, so it doubles as the filter state.
   assign filt = (s2 == s3) ? s2 : hist;
`else
   assign filt = s2;
`endif

   always_ff @(posedge clk) begin
      if (reset) hist <= 1'b1;
      else       hist <= filt;
   end

   assign level = filt;
   assign rise  = filt & ~hist;
   assign fall  = ~filt & hist;

endmodule

// File: rtl/dac7611_serial_rx.sv
// Receiver for the DAC7611 4-wire serial write interface. Decodes frames into
// the code the DAC would latch, flags malformed frames and counts them.
// Optional macro: DAC7611_RX_GLITCH_FILTER_EN (see dac_rx_sync_edge).
//   clk, reset     : fabric clock, synchronous active-high reset
//   dac_signals_15 : [3]=CLK [2]=SDI [1]=LD [0]=CLR, asynchronous
//   dac_code       : last code loaded from a good frame
//   load_pulse     : one-cycle strobe when dac_code updates
//   clr_active     : registered synced CLR-low level
//   frame_err      : one-cycle strobe on LD fall with a wrong bit count
//   err_cnt        : saturating count of frame_err strobes
module dac7611_serial_rx
   import dac7611_pkg::*;
#(
   parameter int DATA_W    = DAC_DATA_W,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [3:0]           dac_signals_15,
   output logic [DATA_W-1:0]    dac_code,
   output logic                 load_pulse,
   output logic                 clr_active,
   output logic                 frame_err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   logic [3:0]           line_lvl, line_rise, line_fall;
   logic [DATA_W-1:0]    shift_reg;
   logic [BIT_CNT_W-1:0] bit_cnt;
   rx_event_e            ev;
   logic                 unused_lines;

   for (genvar i = 0; i < 4; i++) begin : g_line
      dac_rx_sync_edge u_sync (
         .clk   (clk),
         .reset (reset),
         .din   (dac_signals_15[i]),
         .level (line_lvl[i]),
         .rise  (line_rise[i]),
         .fall  (line_fall[i])
      );
   end

   assign unused_lines = ^{line_lvl[CLK_IDX], line_fall[CLK_IDX],
                           line_rise[SDI_IDX], line_fall[SDI_IDX],
                           line_rise[LD_IDX],
                           line_rise[CLR_IDX], line_fall[CLR_IDX]};

   assign ev = rx_event(line_lvl[CLR_IDX], line_fall[LD_IDX],
                        line_rise[CLK_IDX], line_lvl[LD_IDX]);

   always_ff @(posedge clk) begin
      if (reset) begin
         dac_code   <= '0;
         load_pulse <= 1'b0;
         clr_active <= 1'b0;
         frame_err  <= 1'b0;
         err_cnt    <= '0;
         shift_reg  <= '0;
         bit_cnt    <= '0;
      end else begin
         load_pulse <= 1'b0;
         frame_err  <= 1'b0;
         clr_active <= ~line_lvl[CLR_IDX];
         case (ev)
            EV_CLEAR: begin
               dac_code  <= '0;
               shift_reg <= '0;
               bit_cnt   <= '0;
            end
            EV_LATCH: begin
               bit_cnt <= '0;
               if (bit_cnt == BIT_CNT_W'(DATA_W)) begin
                  dac_code   <= shift_reg;
                  load_pulse <= 1'b1;
               end else begin
                  frame_err <= 1'b1;
                  if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
               end
            end
            EV_SHIFT: begin
               shift_reg <= {shift_reg[DATA_W-2:0], line_lvl[SDI_IDX]};
               // Saturate so a runaway frame can never wrap back to a valid count.
               if (bit_cnt != '1) bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
